// File: rtl/pupil_centroid_finder.sv
// Pupil centroid finder: thresholds a grayscale pixel stream inside a column
// window, accumulates dark-pixel statistics per frame, and at each frame wrap
// divides the coordinate sums by the pixel count with a serial restoring
// divider to report the centroid and bounding box. A registered binary mask
// stream is produced alongside for display.
module pupil_centroid_finder #(
  parameter int COORD_W    = 13,
  parameter int CNT_W      = 20,
  parameter int SUM_W      = 32,
  parameter int H_MIN      = 256,
  parameter int H_MAX      = 640,
  parameter int MIN_PIXELS = 64
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iDVAL,
  input  logic [9:0]         iGRAY,
  input  logic [COORD_W-1:0] iH_Cont,
  input  logic [COORD_W-1:0] iV_Cont,
  input  logic [9:0]         iTHRESH,
  output logic               oDVAL,
  output logic [9:0]         oMASK,
  output logic               oRES_VALID,
  output logic               oFOUND,
  output logic [COORD_W-1:0] oCX,
  output logic [COORD_W-1:0] oCY,
  output logic [COORD_W-1:0] oXMIN,
  output logic [COORD_W-1:0] oXMAX,
  output logic [COORD_W-1:0] oYMIN,
  output logic [COORD_W-1:0] oYMAX,
  output logic [CNT_W-1:0]   oCOUNT
);

  localparam logic [COORD_W-1:0] H_LO      = COORD_W'(H_MIN);
  localparam logic [COORD_W-1:0] H_HI      = COORD_W'(H_MAX);
  localparam logic [CNT_W-1:0]   CNT_MIN   = CNT_W'(MIN_PIXELS);
  localparam int                 DIV_CNT_W = $clog2(SUM_W);
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(SUM_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV_X, S_DIV_Y, S_DONE} state_e;

  // Pixel classification and frame-wrap detection
  logic               dark;
  logic               frame_end;
  logic               hold_load;

  // Mask stream
  logic               odval_q, odval_d;
  logic [9:0]         mask_q, mask_d;

  // Per-frame accumulators
  logic [COORD_W-1:0] prev_v_q, prev_v_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [SUM_W:0]     sx_sum, sy_sum;

  // Snapshot of the finished frame
  logic [CNT_W-1:0]   cnt_h_q, cnt_h_d;
  logic [SUM_W-1:0]   sy_h_q, sy_h_d;
  logic [COORD_W-1:0] xmin_h_q, xmin_h_d, xmax_h_q, xmax_h_d;
  logic [COORD_W-1:0] ymin_h_q, ymin_h_d, ymax_h_q, ymax_h_d;

  // Divider and result registers
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   div_rem_q, div_rem_d;
  logic [SUM_W-1:0]   div_quo_q, div_quo_d;
  logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [COORD_W-1:0] qx_q, qx_d;
  logic [CNT_W:0]     trial;
  logic [CNT_W-1:0]   rem_step;
  logic               qbit;
  logic [SUM_W-1:0]   quo_step;

  logic               res_valid_q, res_valid_d;
  logic               found_q, found_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0] oxmin_q, oxmin_d, oxmax_q, oxmax_d;
  logic [COORD_W-1:0] oymin_q, oymin_d, oymax_q, oymax_d;
  logic [CNT_W-1:0]   ocount_q, ocount_d;

  assign dark      = iDVAL && (iH_Cont >= H_LO) && (iH_Cont < H_HI) && (iGRAY < iTHRESH);
  assign frame_end = iDVAL && (iV_Cont < prev_v_q);
  assign hold_load = frame_end && (state_q == S_IDLE);

  // Mask stream, accumulation with saturation, and frame snapshot
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    odval_d  = iDVAL;
    mask_d   = dark ? 10'h3FF : 10'h000;
    prev_v_d = prev_v_q;
    count_d  = count_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    cnt_h_d  = cnt_h_q;
    sy_h_d   = sy_h_q;
    xmin_h_d = xmin_h_q;
    xmax_h_d = xmax_h_q;
    ymin_h_d = ymin_h_q;
    ymax_h_d = ymax_h_q;
    sx_sum   = '0;
    sy_sum   = '0;

    if (iDVAL) prev_v_d = iV_Cont;

    // Snapshot is only taken when the divider is free; otherwise it is dropped.
    if (hold_load) begin
      cnt_h_d  = count_q;
      sy_h_d   = sy_q;
      xmin_h_d = xmin_q;
      xmax_h_d = xmax_q;
      ymin_h_d = ymin_q;
      ymax_h_d = ymax_q;
    end

    // Accumulators restart on every wrap; the wrap pixel belongs to the new frame.
    if (frame_end) begin
      count_d = '0;
      sx_d    = '0;
      sy_d    = '0;
      xmin_d  = '1;
      xmax_d  = '0;
      ymin_d  = '1;
      ymax_d  = '0;
    end

    if (dark) begin
      sx_sum = {1'b0, sx_d} + {{(SUM_W - COORD_W + 1){1'b0}}, iH_Cont};
      sy_sum = {1'b0, sy_d} + {{(SUM_W - COORD_W + 1){1'b0}}, iV_Cont};
      if (count_d != '1) count_d = count_d + CNT_W'(1);
      sx_d = sx_sum[SUM_W] ? '1 : sx_sum[SUM_W-1:0];
      sy_d = sy_sum[SUM_W] ? '1 : sy_sum[SUM_W-1:0];
      if (iH_Cont < xmin_d) xmin_d = iH_Cont;
      if (iH_Cont > xmax_d) xmax_d = iH_Cont;
      if (iV_Cont < ymin_d) ymin_d = iV_Cont;
      if (iV_Cont > ymax_d) ymax_d = iV_Cont;
    end
  end

  // Registers for mask stream, accumulators and snapshot
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      odval_q  <= 1'b0;
      mask_q   <= '0;
      prev_v_q <= '0;
      count_q  <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      xmin_q   <= '1;
      xmax_q   <= '0;
      ymin_q   <= '1;
      ymax_q   <= '0;
      cnt_h_q  <= '0;
      sy_h_q   <= '0;
      xmin_h_q <= '1;
      xmax_h_q <= '0;
      ymin_h_q <= '1;
      ymax_h_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      odval_q  <= odval_d;
      mask_q   <= mask_d;
      prev_v_q <= prev_v_d;
      count_q  <= count_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      cnt_h_q  <= cnt_h_d;
      sy_h_q   <= sy_h_d;
      xmin_h_q <= xmin_h_d;
      xmax_h_q <= xmax_h_d;
      ymin_h_q <= ymin_h_d;
      ymax_h_q <= ymax_h_d;
    end
  end

  // FSM next state, one restoring-divider step per cycle, and result loading
  always_comb begin
    state_d     = state_q;
    div_rem_d   = div_rem_q;
    div_quo_d   = div_quo_q;
    div_cnt_d   = div_cnt_q;
    qx_d        = qx_q;
    res_valid_d = 1'b0;
    found_d     = found_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    oxmin_d     = oxmin_q;
    oxmax_d     = oxmax_q;
    oymin_d     = oymin_q;
    oymax_d     = oymax_q;
    ocount_d    = ocount_q;

    // Remainder stays below the divisor, so the difference fits in CNT_W bits.
    trial = {div_rem_q, div_quo_q[SUM_W-1]};
    if (trial >= {1'b0, cnt_h_q}) begin
      rem_step = trial[CNT_W-1:0] - cnt_h_q;
      qbit     = 1'b1;
    end else begin
      rem_step = trial[CNT_W-1:0];
      qbit     = 1'b0;
    end
    quo_step = {div_quo_q[SUM_W-2:0], qbit};

    case (state_q)
      S_IDLE: begin
        if (frame_end) begin
          if (count_q >= CNT_MIN) begin
            state_d   = S_DIV_X;
            div_quo_d = sx_q;
            div_rem_d = '0;
            div_cnt_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DIV_X: begin
        div_rem_d = rem_step;
        div_quo_d = quo_step;
        div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        if (div_cnt_q == DIV_LAST) begin
          qx_d      = quo_step[COORD_W-1:0];
          div_quo_d = sy_h_q;
          div_rem_d = '0;
          div_cnt_d = '0;
          state_d   = S_DIV_Y;
        end
      end
      S_DIV_Y: begin
        div_rem_d = rem_step;
        div_quo_d = quo_step;
        div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        if (div_cnt_q == DIV_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        res_valid_d = 1'b1;
        ocount_d    = cnt_h_q;
        if (cnt_h_q >= CNT_MIN) begin
          found_d = 1'b1;
          cx_d    = qx_q;
          cy_d    = div_quo_q[COORD_W-1:0];
          oxmin_d = xmin_h_q;
          oxmax_d = xmax_h_q;
          oymin_d = ymin_h_q;
          oymax_d = ymax_h_q;
        end else begin
          found_d = 1'b0;
          cx_d    = '0;
          cy_d    = '0;
          oxmin_d = '0;
          oxmax_d = '0;
          oymin_d = '0;
          oymax_d = '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, divider and result registers; reset discards any division in flight
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_cnt_q   <= '0;
      qx_q        <= '0;
      res_valid_q <= 1'b0;
      found_q     <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      oxmin_q     <= '0;
      oxmax_q     <= '0;
      oymin_q     <= '0;
      oymax_q     <= '0;
      ocount_q    <= '0;
    end else begin
      state_q     <= state_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_cnt_q   <= div_cnt_d;
      qx_q        <= qx_d;
      res_valid_q <= res_valid_d;
      found_q     <= found_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      oxmin_q     <= oxmin_d;
      oxmax_q     <= oxmax_d;
      oymin_q     <= oymin_d;
      oymax_q     <= oymax_d;
      ocount_q    <= ocount_d;
    end
  end

  assign oDVAL      = odval_q;
  assign oMASK      = mask_q;
  assign oRES_VALID = res_valid_q;
  assign oFOUND     = found_q;
  assign oCX        = cx_q;
  assign oCY        = cy_q;
  assign oXMIN      = oxmin_q;
  assign oXMAX      = oxmax_q;
  assign oYMIN      = oymin_q;
  assign oYMAX      = oymax_q;
  assign oCOUNT     = ocount_q;

endmodule

// File: tb/tb_pupil_centroid_finder.sv
// Directed bench for pupil_centroid_finder: expected frame results are queued
// when the wrap pixel is driven and compared when oRES_VALID pulses; the mask
// stream is compared every cycle.
module tb_pupil_centroid_finder;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iDVAL;
  logic [9:0]  iGRAY;
  logic [12:0] iH_Cont;
  logic [12:0] iV_Cont;
  logic [9:0]  iTHRESH;
  logic        oDVAL;
  logic [9:0]  oMASK;
  logic        oRES_VALID;
  logic        oFOUND;
  logic [12:0] oCX, oCY, oXMIN, oXMAX, oYMIN, oYMAX;
  logic [19:0] oCOUNT;

  typedef struct {
    logic [19:0] count;
    logic [12:0] cx, cy, xmin, xmax, ymin, ymax;
    logic        found;
    int          lat;
    int          wrap_cyc;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  pupil_centroid_finder dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iGRAY(iGRAY),
    .iH_Cont(iH_Cont), .iV_Cont(iV_Cont), .iTHRESH(iTHRESH),
    .oDVAL(oDVAL), .oMASK(oMASK), .oRES_VALID(oRES_VALID), .oFOUND(oFOUND),
    .oCX(oCX), .oCY(oCY), .oXMIN(oXMIN), .oXMAX(oXMAX),
    .oYMIN(oYMIN), .oYMAX(oYMAX), .oCOUNT(oCOUNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: mask expectation from the threshold rule, result scoreboard pop.
  task automatic tick();
    logic       exp_dv;
    logic [9:0] exp_mk;
    res_t       r;
    exp_dv = !iRST && iDVAL;
    exp_mk = (!iRST && iDVAL && iH_Cont >= 13'd256 && iH_Cont < 13'd640 && iGRAY < iTHRESH)
             ? 10'h3FF : 10'h000;
    @(posedge iCLK);
    #1;
    cyc++;
    check("odval", 32'(oDVAL), 32'(exp_dv));
    check("omask", 32'(oMASK), 32'(exp_mk));
    if (exp_q.size() == 0) begin
      check("no_res_valid", 32'(oRES_VALID), 32'd0);
    end else if (oRES_VALID) begin
      r = exp_q.pop_front();
      check("latency", 32'(cyc - r.wrap_cyc), 32'(r.lat));
      check("count", 32'(oCOUNT), 32'(r.count));
      check("found", 32'(oFOUND), 32'(r.found));
      check("cx",    32'(oCX),    32'(r.cx));
      check("cy",    32'(oCY),    32'(r.cy));
      check("xmin",  32'(oXMIN),  32'(r.xmin));
      check("xmax",  32'(oXMAX),  32'(r.xmax));
      check("ymin",  32'(oYMIN),  32'(r.ymin));
      check("ymax",  32'(oYMAX),  32'(r.ymax));
    end
  endtask

  task automatic idle(input int n);
    iDVAL = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic px(input int gray, input int h, input int v);
    iDVAL   = 1'b1;
    iGRAY   = 10'(gray);
    iH_Cont = 13'(h);
    iV_Cont = 13'(v);
    tick();
    iDVAL = 1'b0;
  endtask

  task automatic expect_res(input int count, input int cx, input int cy, input int xmin,
                            input int xmax, input int ymin, input int ymax,
                            input logic found, input int lat);
    res_t r;
    r.count = 20'(count); r.cx = 13'(cx); r.cy = 13'(cy);
    r.xmin = 13'(xmin); r.xmax = 13'(xmax); r.ymin = 13'(ymin); r.ymax = 13'(ymax);
    r.found = found; r.lat = lat; r.wrap_cyc = cyc;
    exp_q.push_back(r);
  endtask

  task automatic wait_result(input int budget);
    int n = 0;
    iDVAL = 1'b0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("result_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dval"},  32'(oDVAL),      32'd0);
    check({tag, "_mask"},  32'(oMASK),      32'd0);
    check({tag, "_rv"},    32'(oRES_VALID), 32'd0);
    check({tag, "_found"}, 32'(oFOUND),     32'd0);
    check({tag, "_cx"},    32'(oCX),        32'd0);
    check({tag, "_cy"},    32'(oCY),        32'd0);
    check({tag, "_xmin"},  32'(oXMIN),      32'd0);
    check({tag, "_xmax"},  32'(oXMAX),      32'd0);
    check({tag, "_ymin"},  32'(oYMIN),      32'd0);
    check({tag, "_ymax"},  32'(oYMAX),      32'd0);
    check({tag, "_count"}, 32'(oCOUNT),     32'd0);
  endtask

  // 10x10 dark block at columns 500-509, rows 400-409
  task automatic dark_block();
    for (int r = 400; r < 410; r++)
      for (int c = 500; c < 510; c++)
        px(20, c, r);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1; iDVAL = 1'b0; iGRAY = '0; iH_Cont = '0; iV_Cont = '0; iTHRESH = 10'd100;
    idle(3);
    check_zero("reset");
    iRST = 1'b0;

    // Mask stream: dark pixel in window, then invalid cycle
    px(50, 400, 0);
    idle(1);
    iRST = 1'b1;
    idle(1);
    iRST = 1'b0;

    // Found frame, with out-of-window and equal-to-threshold pixels that must not count
    dark_block();
    px(10, 200, 409);
    px(10, 640, 409);
    px(10, 255, 409);
    px(100, 505, 409);
    expect_res(100, 504, 404, 500, 509, 400, 409, 1'b1, 66);
    px(900, 300, 0);
    wait_result(200);

    // Single dark pixel: below the minimum, divide skipped
    px(20, 300, 5);
    expect_res(1, 0, 0, 0, 0, 0, 0, 1'b0, 2);
    px(900, 300, 0);
    wait_result(20);

    // Second wrap during division is dropped; first result intact and held
    dark_block();
    expect_res(100, 504, 404, 500, 509, 400, 409, 1'b1, 66);
    px(900, 256, 0);
    idle(8);
    px(20, 300, 5);
    px(900, 300, 0);
    wait_result(200);
    idle(80);
    check("hold_count", 32'(oCOUNT), 32'd100);
    check("hold_cx", 32'(oCX), 32'd504);

    // Reset mid-divide discards the division and clears outputs
    dark_block();
    px(900, 300, 0);
    idle(20);
    iRST = 1'b1;
    #1;
    check_zero("rst_async");
    tick();
    check_zero("rst_edge");
    iRST = 1'b0;
    idle(100);

    // Recovery after a full new frame
    px(20, 300, 5);
    expect_res(1, 0, 0, 0, 0, 0, 0, 1'b0, 2);
    px(900, 300, 0);
    wait_result(20);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
